// File: rtl/ps2_movement_decoder.sv
// PS/2 set-2 receiver that tracks held movement keys and drives one-hot movement flags.
// Define PS2_WASD_EN to also map the non-extended W/A/S/D keys onto the arrow-key held bits.
module ps2_movement_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMER_WIDTH    = 17
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       turn_right,
  output logic       turn_left,
  output logic       move_forward,
  output logic       move_backward,
  output logic [3:0] held_keys,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_error
);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_E0, P_F0, P_E0F0} pfx_state_t;

  // Held-bit / flag index: {right,left,up,down}
  localparam logic [1:0] KEY_DOWN  = 2'd0;
  localparam logic [1:0] KEY_UP    = 2'd1;
  localparam logic [1:0] KEY_LEFT  = 2'd2;
  localparam logic [1:0] KEY_RIGHT = 2'd3;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]             clk_sync_q, clk_sync_d;
  logic [1:0]             dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  rx_state_t              rx_state_q, rx_state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   scan_valid_q, scan_valid_d;
  logic [7:0]             scan_code_q, scan_code_d;
  logic                   frame_error_q, frame_error_d;
  pfx_state_t             pfx_q, pfx_d;
  logic [3:0]             held_q, held_d;
  logic [1:0]             last_key_q, last_key_d;
  logic                   last_valid_q, last_valid_d;
  logic [3:0]             flags_q, flags_d;

  logic                   ps2_fall;
  logic                   bit_in;
  logic                   good_byte;
  logic                   ext_hit;
  logic [1:0]             ext_idx;
`ifdef PS2_WASD_EN
  logic                   wasd_hit;
  logic [1:0]             wasd_idx;
`endif

  // Two-flop synchronizers plus a delayed copy of the clock for edge detection
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    clk_prev_d = clk_sync_q[1];
  end

  assign ps2_fall = clk_prev_q & ~clk_sync_q[1];
  assign bit_in   = dat_sync_q[1];

  always_comb begin
    rx_state_d    = rx_state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    timer_d       = timer_q;
    scan_valid_d  = 1'b0;
    scan_code_d   = scan_code_q;
    frame_error_d = 1'b0;
    good_byte     = 1'b0;
    if (ps2_fall) begin
      // An edge always wins over a coincident timeout
      timer_d = '0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!bit_in) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = RX_PARITY;
          end
        end
        RX_PARITY: begin
          parity_d   = bit_in;
          rx_state_d = RX_STOP;
        end
        RX_STOP: begin
          rx_state_d = RX_IDLE;
          if (bit_in && (^{shift_q, parity_q})) begin
            scan_valid_d = 1'b1;
            scan_code_d  = shift_q;
            good_byte    = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end else if (rx_state_q != RX_IDLE) begin
      if (timer_q == TIMER_LAST) begin
        frame_error_d = 1'b1;
        rx_state_d    = RX_IDLE;
        timer_d       = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_comb begin
    ext_hit = 1'b1;
    ext_idx = KEY_UP;
    case (shift_q)
      8'h75:   ext_idx = KEY_UP;
      8'h72:   ext_idx = KEY_DOWN;
      8'h6B:   ext_idx = KEY_LEFT;
      8'h74:   ext_idx = KEY_RIGHT;
      default: ext_hit = 1'b0;
    endcase
  end

`ifdef PS2_WASD_EN
  always_comb begin
    wasd_hit = 1'b1;
    wasd_idx = KEY_UP;
    case (shift_q)
      8'h1D:   wasd_idx = KEY_UP;
      8'h1B:   wasd_idx = KEY_DOWN;
      8'h1C:   wasd_idx = KEY_LEFT;
      8'h23:   wasd_idx = KEY_RIGHT;
      default: wasd_hit = 1'b0;
    endcase
  end
`endif

  // Prefix tracking runs on the same cycle the byte is accepted, so held bits land with scan_valid
  always_comb begin
    pfx_d        = pfx_q;
    held_d       = held_q;
    last_key_d   = last_key_q;
    last_valid_d = last_valid_q;
    if (good_byte) begin
      case (pfx_q)
        P_IDLE: begin
          if (shift_q == 8'hE0) begin
            pfx_d = P_E0;
          end else if (shift_q == 8'hF0) begin
            pfx_d = P_F0;
          end else begin
`ifdef PS2_WASD_EN
            if (wasd_hit) begin
              held_d[wasd_idx] = 1'b1;
              last_key_d       = wasd_idx;
              last_valid_d     = 1'b1;
            end
`endif
            pfx_d = P_IDLE;
          end
        end
        P_E0: begin
          if (shift_q == 8'hF0) begin
            pfx_d = P_E0F0;
          end else begin
            if (ext_hit) begin
              held_d[ext_idx] = 1'b1;
              last_key_d      = ext_idx;
              last_valid_d    = 1'b1;
            end
            pfx_d = P_IDLE;
          end
        end
        P_F0: begin
`ifdef PS2_WASD_EN
          if (wasd_hit) begin
            held_d[wasd_idx] = 1'b0;
          end
`endif
          pfx_d = P_IDLE;
        end
        P_E0F0: begin
          if (ext_hit) begin
            held_d[ext_idx] = 1'b0;
          end
          pfx_d = P_IDLE;
        end
        default: pfx_d = P_IDLE;
      endcase
    end
  end

  // Most recent make wins while held; otherwise fall back to up > down > right > left
  always_comb begin
    flags_d = 4'b0000;
    if (held_q != 4'b0000) begin
      if (last_valid_q && held_q[last_key_q]) begin
        flags_d[last_key_q] = 1'b1;
      end else if (held_q[KEY_UP]) begin
        flags_d[KEY_UP] = 1'b1;
      end else if (held_q[KEY_DOWN]) begin
        flags_d[KEY_DOWN] = 1'b1;
      end else if (held_q[KEY_RIGHT]) begin
        flags_d[KEY_RIGHT] = 1'b1;
      end else begin
        flags_d[KEY_LEFT] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q    <= 2'b11;
      dat_sync_q    <= 2'b11;
      clk_prev_q    <= 1'b1;
      rx_state_q    <= RX_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      timer_q       <= '0;
      scan_valid_q  <= 1'b0;
      scan_code_q   <= 8'h00;
      frame_error_q <= 1'b0;
      pfx_q         <= P_IDLE;
      held_q        <= 4'b0000;
      last_key_q    <= KEY_DOWN;
      last_valid_q  <= 1'b0;
      flags_q       <= 4'b0000;
    end else begin
      clk_sync_q    <= clk_sync_d;
      dat_sync_q    <= dat_sync_d;
      clk_prev_q    <= clk_prev_d;
      rx_state_q    <= rx_state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      timer_q       <= timer_d;
      scan_valid_q  <= scan_valid_d;
      scan_code_q   <= scan_code_d;
      frame_error_q <= frame_error_d;
      pfx_q         <= pfx_d;
      held_q        <= held_d;
      last_key_q    <= last_key_d;
      last_valid_q  <= last_valid_d;
      flags_q       <= flags_d;
    end
  end

  assign turn_right    = flags_q[KEY_RIGHT];
  assign turn_left     = flags_q[KEY_LEFT];
  assign move_forward  = flags_q[KEY_UP];
  assign move_backward = flags_q[KEY_DOWN];
  assign held_keys     = held_q;
  assign scan_valid    = scan_valid_q;
  assign scan_code     = scan_code_q;
  assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_ps2_movement_decoder.sv
// Directed bench for ps2_movement_decoder: drives PS/2 frames on the raw pins and checks held keys and flags.
module tb_ps2_movement_decoder;

  localparam int TIMEOUT = 200;

  logic       clock;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       turn_right;
  logic       turn_left;
  logic       move_forward;
  logic       move_backward;
  logic [3:0] held_keys;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_error;

  int errors = 0;
  int checks = 0;
  int sv_cnt = 0;
  int fe_cnt = 0;
  int sv_base;
  int fe_base;

  logic [3:0] snap_held;
  logic [3:0] snap_flags0;
  logic [3:0] snap_flags1;
  logic       snap_pending;
  logic [3:0] flags;

  ps2_movement_decoder #(.TIMEOUT_CYCLES(TIMEOUT), .TIMER_WIDTH(8)) dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .turn_right(turn_right), .turn_left(turn_left),
    .move_forward(move_forward), .move_backward(move_backward),
    .held_keys(held_keys), .scan_valid(scan_valid), .scan_code(scan_code),
    .frame_error(frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign flags = {turn_right, turn_left, move_forward, move_backward};

  // Pulse counters sampled away from the active edge
  always @(negedge clock) begin
    if (scan_valid) sv_cnt++;
    if (frame_error) fe_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sends bits[0..n-1]; records held/flags on the scan_valid cycle and the cycle after
  task automatic sendBits(input logic [10:0] bits, input int n);
    for (int b = 0; b < n; b++) begin
      @(negedge clock);
      ps2_dat = bits[b];
      repeat (4) @(negedge clock);
      ps2_clk = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clock);
        if (snap_pending) begin
          snap_flags1  = flags;
          snap_pending = 1'b0;
        end
        if (scan_valid) begin
          snap_held    = held_keys;
          snap_flags0  = flags;
          snap_pending = 1'b1;
        end
      end
      ps2_clk = 1'b1;
      repeat (4) @(negedge clock);
    end
    ps2_dat = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic bad_parity);
    logic par;
    par = (~^data) ^ bad_parity;
    sendBits({1'b1, par, data, 1'b0}, 11);
    repeat (10) @(negedge clock);
  endtask

  initial begin
    resetn       = 1'b0;
    ps2_clk      = 1'b1;
    ps2_dat      = 1'b1;
    snap_held    = 4'h0;
    snap_flags0  = 4'h0;
    snap_flags1  = 4'h0;
    snap_pending = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("reset_flags", {12'h0, flags}, 16'h0);
    checkOutput("reset_held", {12'h0, held_keys}, 16'h0);
    checkOutput("reset_scan", {6'h0, scan_valid, frame_error, scan_code}, 16'h0);
    resetn = 1'b1;
    repeat (4) @(negedge clock);

    // 1: up-arrow make
    sv_base = sv_cnt;
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("t1_scan_valid_count", 16'(sv_cnt - sv_base), 16'd2);
    checkOutput("t1_scan_code", {8'h0, scan_code}, 16'h0075);
    checkOutput("t1_held_at_valid", {12'h0, snap_held}, 16'h2);
    checkOutput("t1_flags_at_valid", {12'h0, snap_flags0}, 16'h0);
    checkOutput("t1_flags_next", {12'h0, snap_flags1}, 16'h2);
    checkOutput("t1_flags_steady", {12'h0, flags}, 16'h2);

    // 2: up-arrow break
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("t2_held", {12'h0, held_keys}, 16'h0);
    checkOutput("t2_flags", {12'h0, flags}, 16'h0);

    // 3: newest key wins, release falls back to up
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("t3_up_only", {12'h0, flags}, 16'h2);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h6B, 1'b0);
    checkOutput("t3_held_up_left", {12'h0, held_keys}, 16'h6);
    checkOutput("t3_flags_left", {12'h0, flags}, 16'h4);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h6B, 1'b0);
    checkOutput("t3_flags_back_up", {12'h0, flags}, 16'h2);

    // 4: parity error
    sv_base = sv_cnt;
    fe_base = fe_cnt;
    applyStimulus(8'h75, 1'b1);
    checkOutput("t4_frame_error_count", 16'(fe_cnt - fe_base), 16'd1);
    checkOutput("t4_no_scan_valid", 16'(sv_cnt - sv_base), 16'd0);
    checkOutput("t4_held", {12'h0, held_keys}, 16'h2);
    checkOutput("t4_scan_code_kept", {8'h0, scan_code}, 16'h006B);

    // 5: stalled frame times out, then a good down-arrow make
    fe_base = fe_cnt;
    sendBits(11'b000_0000_0000, 5);
    repeat (TIMEOUT + 60) @(negedge clock);
    checkOutput("t5_timeout_error", 16'(fe_cnt - fe_base), 16'd1);
    checkOutput("t5_held_kept", {12'h0, held_keys}, 16'h2);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h72, 1'b0);
    checkOutput("t5_held_up_down", {12'h0, held_keys}, 16'h3);
    checkOutput("t5_flags_back", {12'h0, flags}, 16'h1);

    // 6: async reset mid-frame while right held, then W
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h74, 1'b0);
    checkOutput("t6_flags_right", {12'h0, flags}, 16'h8);
    sendBits(11'b000_0101_0110, 4);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t6_async_flags", {12'h0, flags}, 16'h0);
    checkOutput("t6_async_held", {12'h0, held_keys}, 16'h0);
    checkOutput("t6_async_scan", {6'h0, scan_valid, frame_error, scan_code}, 16'h0);
    repeat (4) @(negedge clock);
    resetn = 1'b1;
    repeat (4) @(negedge clock);
    applyStimulus(8'h1D, 1'b0);
    checkOutput("t6_scan_code_w", {8'h0, scan_code}, 16'h001D);
`ifdef PS2_WASD_EN
    checkOutput("t6_w_held", {12'h0, held_keys}, 16'h2);
    checkOutput("t6_w_flags", {12'h0, flags}, 16'h2);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("t6_up_break_clears_w", {12'h0, held_keys}, 16'h0);
`else
    checkOutput("t6_w_held", {12'h0, held_keys}, 16'h0);
    checkOutput("t6_w_flags", {12'h0, flags}, 16'h0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("t6_prefix_ok_after_w", {12'h0, held_keys}, 16'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
